scan_mux: RTL
=============

# scan_mux

Parametrised N-channel, W-bit registered multiplexer with two modes. In manual mode it forwards a host-selected channel. In auto-scan mode it dwells on each channel in turn and emits one tagged sample per channel. Output goes through a valid/ready register stage. It sits between banks of parallel sources (switches, sensor registers, counters) and a single-lane consumer such as a seven-segment driver or UART formatter on the Basys3 board.

## Interface
- CHANNELS, default 16: number of input channels, 2..64.
- WIDTH, default 8: bits per channel, ≥1.
- DWELL, default 4: cycles spent on each channel in scan mode, ≥1.
- SEL_W (localparam) = $clog2(CHANNELS): channel index width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- ch_en  in  CHANNELS  per-channel scan enable mask.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  SEL_W  manual channel select.
- load  in  1  strobe: latch sel_in into the current channel.
- out_data  out  WIDTH  captured sample.
- out_ch  out  SEL_W  channel index of out_data.
- out_valid  out  1  sample present in output register.
- out_ready  in  1  consumer accepts the sample.

## Operation
- Internal state: cur_ch (SEL_W), dwell counter (width $clog2(DWELL)+1), output register {out_data, out_ch, out_valid}.
- free = !out_valid || out_ready. A capture writes in_data[cur_ch] and cur_ch into the output register and sets out_valid=1. When free holds and no capture occurs, out_valid clears to 0.
- Manual mode (mode=0):
  - load=1 with sel_in < CHANNELS sets cur_ch ← sel_in.
  - load with sel_in ≥ CHANNELS is ignored.
  - A capture happens every cycle in which free is true.
  - The dwell counter is held at 0.
- Scan mode (mode=1):
  - load is ignored.
  - The dwell counter increments each cycle while below DWELL-1.
  - At dwell = DWELL-1 with free=1:
    - If ch_en[cur_ch]=1, capture.
    - cur_ch ← next enabled channel, searching cur_ch+1 upward with wrap at CHANNELS-1 → 0 and cur_ch itself checked last.
    - dwell ← 0.
  - At dwell = DWELL-1 with free=0 (stall): dwell and cur_ch hold. No sample is lost or skipped.
  - All ch_en=0: no captures, cur_ch holds, dwell keeps cycling.
  - Single enabled channel: cur_ch stays on it and a sample is produced every DWELL cycles.
- Mode change takes effect on the next edge and clears dwell to 0. cur_ch is retained. A pending output sample is retained until accepted.
- Reset (any cycle, including mid-stall) forces cur_ch=0, dwell=0, out_data=0, out_ch=0, out_valid=0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Manual latency: load sampled at edge k. Data from the new channel appears on out_data after edge k+1, so it is visible 2 cycles after load is asserted.
- Manual throughput: 1 sample/cycle with out_ready held high. Live in_data changes appear 1 cycle later.
- Scan throughput without backpressure: one sample per DWELL cycles. Enabled channels appear in ascending index order with wrap.
- While out_valid=1 and out_ready=0, out_data and out_ch are stable.
- Simultaneous accept and capture in the same cycle: the new sample replaces the old one with no bubble.

## Configuration
- SCAN_MUX_SKIP_EN defined: ch_en is honoured as above. Disabled channels are skipped without capture.
- SCAN_MUX_SKIP_EN undefined: ch_en is ignored (port remains, unused). Every channel 0..CHANNELS-1 is visited and captured in sequence, and next channel = (cur_ch+1) mod CHANNELS.

## Test plan
- Reset: rst_n=0 for 3 cycles with arbitrary inputs. Required: out_valid=0, out_data=0, out_ch=0. Reassert rst_n=0 mid-stall and the same values return on the next edge.
- Manual: channel c holds value 8'h10+c, out_ready=1, load with sel_in=5. Required: 2 cycles later out_data=8'h15 and out_ch=5. A load with sel_in=20 when CHANNELS=20 is ignored.
- Scan, no backpressure (CHANNELS=16, DWELL=4, ch_en=16'hFFFF): out_ch sequence 0,1,...,15,0 with one out_valid pulse every 4 cycles.
- Skip (macro defined, ch_en=16'h8011): out_ch sequence 0,4,15,0. With ch_en=0, out_valid is never asserted.
- Backpressure: hold out_ready=0 for 10 cycles after capturing channel 3. Required: out_data/out_ch stable at 3, then release gives channels 3,4 with no loss.
- Mode switch: toggle mode 1→0 mid-dwell on channel 7. Required: manual captures of channel 7 start the next cycle. Returning to scan restarts dwell at 0 on channel 7.

Source files
------------

// File: rtl/scan_mux.sv
// N-channel registered multiplexer: manual channel select or auto-scan with per-channel dwell.
// Define SCAN_MUX_SKIP_EN to honour ch_en in scan mode; otherwise every channel is visited.
module scan_mux #(
   parameter int unsigned CHANNELS = 16,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DWELL    = 4,
   localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       ch_en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      load,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int unsigned DW_W = $clog2(DWELL) + 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   logic [SEL_W-1:0] r_cur_ch;
   logic [DW_W-1:0]  r_dwell;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_ch;
   logic             r_valid;

   logic             w_free;
   logic             w_at_last;
   logic             w_cur_en;
   logic             w_capture;
   logic             w_sel_ok;
   logic [SEL_W-1:0] w_next_ch;
   logic [WIDTH-1:0] w_sel_data;

   assign w_free     = !r_valid || out_ready;
   assign w_at_last  = (r_dwell == DWELL_LAST);
   assign w_sel_data = in_data[32'(r_cur_ch)*WIDTH +: WIDTH];
   assign w_capture  = mode ? (w_at_last && w_cur_en) : 1'b1;

   // Out-of-range selects can only exist when CHANNELS is not a power of two.
   if ((2**SEL_W) == CHANNELS) begin : g_sel_full
      assign w_sel_ok = 1'b1;
   end else begin : g_sel_part
      assign w_sel_ok = (32'(sel_in) < CHANNELS);
   end

`ifdef SCAN_MUX_SKIP_EN
   assign w_cur_en = ch_en[r_cur_ch];

   // Search upward from cur_ch+1 with wrap; cur_ch itself is examined last.
   always_comb begin
      logic        v_found;
      int unsigned v_idx;
      v_found   = 1'b0;
      w_next_ch = r_cur_ch;
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
         v_idx = 32'(r_cur_ch) + i;
         if (v_idx >= CHANNELS) v_idx = v_idx - CHANNELS;
         if (!v_found && ch_en[SEL_W'(v_idx)]) begin
            v_found   = 1'b1;
            w_next_ch = SEL_W'(v_idx);
         end
      end
   end
`else
   logic w_unused_ch_en;
   assign w_unused_ch_en = ^ch_en;
   assign w_cur_en       = 1'b1;
   assign w_next_ch      = (r_cur_ch == SEL_W'(CHANNELS - 1)) ? '0 : r_cur_ch + 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur_ch <= '0;
         r_dwell  <= '0;
         r_data   <= '0;
         r_ch     <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_free) begin
            r_valid <= w_capture;
            if (w_capture) begin
               r_data <= w_sel_data;
               r_ch   <= r_cur_ch;
            end
         end
         if (!mode) begin
            r_dwell <= '0;
            if (load && w_sel_ok) r_cur_ch <= sel_in;
         end else if (!w_at_last) begin
            r_dwell <= r_dwell + 1'b1;
         end else if (w_free) begin
            r_dwell  <= '0;
            r_cur_ch <= w_next_ch;
         end
      end
   end

   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = r_valid;

endmodule
